// File: rtl/cnn_top_pkg.sv
// Shared FSM state type and derived-geometry helpers for cnn_top.
package cnn_top_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_IFM,
    LOAD_WGT,
    CONV,
    POOL,
    FC,
    DONE
  } state_t;

  function automatic int calc_oh(int ifm_size, int k, int stride, int pad);
    return (ifm_size - k + 2 * pad) / stride + 1;
  endfunction

  function automatic int calc_ph(int oh, int kp, int sp);
    return (oh - kp) / sp + 1;
  endfunction

  function automatic int calc_in_feature(int co, int ph);
    return co * ph * ph;
  endfunction

  localparam int OH_DEF         = calc_oh(8, 3, 1, 1);
  localparam int PH_DEF         = calc_ph(OH_DEF, 2, 2);
  localparam int IN_FEATURE_DEF = calc_in_feature(2, PH_DEF);

endpackage

// File: rtl/cnn_mac.sv
// Signed multiply-accumulate; clr restarts the sum (loading the product when en is also high).
module cnn_mac #(
  parameter int A_W   = 16,
  parameter int B_W   = 8,
  parameter int ACC_W = 32
) (
  input  logic                    clk1,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [ACC_W-1:0] prod;

  always_comb prod = ACC_W'(a) * ACC_W'(b);

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= en ? prod : '0;
    else if (en)  acc <= acc + prod;
  end

endmodule

// File: rtl/cnn_top.sv
// Small CNN engine: load IFM/weights, conv (+ReLU), max-pool, 8-lane FC.
// Build option CNN_TOP_FC_RELU_EN clamps negative FC outputs to zero.
module cnn_top
  import cnn_top_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int WEIGHT_WIDTH = 8,
  parameter int IFM_WIDTH    = 16,
  parameter int IFM_SIZE     = 8,
  parameter int KERNEL_SIZE  = 3,
  parameter int STRIDE       = 1,
  parameter int PAD          = 1,
  parameter int RELU         = 1,
  parameter int CI           = 2,
  parameter int CO           = 2,
  parameter int KERNEL_POOL  = 2,
  parameter int STRIDE_POOL  = 2,
  parameter int OUT_FEATURE  = 4
) (
  input  logic                          clk1,
  input  logic                          rst_n,
  input  logic                          start_conv,
  input  logic signed [IFM_WIDTH-1:0]   ifm,
  input  logic signed [WEIGHT_WIDTH-1:0] wgt,
  input  logic [8*WEIGHT_WIDTH-1:0]     wgt_fc1,
  output logic                          ifm_read,
  output logic                          wgt_read,
  output logic                          wgt_read_fc_1,
  output logic                          end_pool,
  output logic                          end_op,
  output logic                          out_valid,
  output logic signed [DATA_WIDTH-1:0]  data_output
);

  localparam int OH         = calc_oh(IFM_SIZE, KERNEL_SIZE, STRIDE, PAD);
  localparam int PH         = calc_ph(OH, KERNEL_POOL, STRIDE_POOL);
  localparam int IN_FEATURE = calc_in_feature(CO, PH);
  localparam int N_IFM      = CI * IFM_SIZE * IFM_SIZE;
  localparam int N_WGT      = CO * CI * KERNEL_SIZE * KERNEL_SIZE;
  localparam int N_CONV     = CO * OH * OH;
  localparam int WPO        = IN_FEATURE / 8;
  localparam int N_FCW      = OUT_FEATURE * WPO;
  localparam int IB_AW      = $clog2(N_IFM);
  localparam int WB_AW      = $clog2(N_WGT);
  localparam int CB_AW      = $clog2(N_CONV);
  localparam int PB_AW      = $clog2(IN_FEATURE);
  localparam int CAP_AW     = (IB_AW > WB_AW) ? IB_AW : WB_AW;

  state_t state, state_n;
  logic [31:0] rd_cnt;
  logic [CAP_AW-1:0] cap_addr;
  logic ifm_cap, wgt_cap, fc_cap;
  logic [31:0] cv_co, cv_r, cv_c, cv_ci, cv_kr, cv_kc;
  logic tap_first, tap_last, pos_last;
  logic cv_wr;
  logic [CB_AW-1:0] cv_wr_addr;
  logic [31:0] pl_co, pl_r, pl_c, pl_idx;
  logic [31:0] fc_w, fc_out_cnt;
  logic fc_pend, fc_clr, conv_clr, conv_en;
  logic signed [IFM_WIDTH-1:0]    conv_a;
  logic signed [WEIGHT_WIDTH-1:0] conv_b;
  logic signed [DATA_WIDTH-1:0]   conv_acc, pool_max, fc_sum, fc_res;
  logic signed [DATA_WIDTH-1:0]   fc_acc [8];

  logic signed [IFM_WIDTH-1:0]    ifm_buf  [N_IFM];
  logic signed [WEIGHT_WIDTH-1:0] wgt_buf  [N_WGT];
  logic signed [DATA_WIDTH-1:0]   conv_buf [N_CONV];
  logic signed [DATA_WIDTH-1:0]   pool_buf [IN_FEATURE];

  assign tap_first = (cv_ci == 0) && (cv_kr == 0) && (cv_kc == 0);
  assign tap_last  = (cv_ci == CI-1) && (cv_kr == KERNEL_SIZE-1) && (cv_kc == KERNEL_SIZE-1);
  assign pos_last  = (cv_co == CO-1) && (cv_r == OH-1) && (cv_c == OH-1);
  assign conv_en   = (state == CONV);
  assign conv_clr  = conv_en && tap_first;
  assign fc_clr    = fc_cap && (fc_w == 0);

  always_comb begin
    state_n       = state;
    ifm_read      = 1'b0;
    wgt_read      = 1'b0;
    wgt_read_fc_1 = 1'b0;
    end_op        = 1'b0;
    case (state)
      IDLE:     if (start_conv) state_n = LOAD_IFM;
      LOAD_IFM: begin
        ifm_read = 1'b1;
        if (rd_cnt == N_IFM-1) state_n = LOAD_WGT;
      end
      LOAD_WGT: begin
        wgt_read = 1'b1;
        if (rd_cnt == N_WGT-1) state_n = CONV;
      end
      CONV:     if (tap_last && pos_last) state_n = POOL;
      POOL:     if (pl_idx == IN_FEATURE-1) state_n = FC;
      FC: begin
        wgt_read_fc_1 = (rd_cnt < N_FCW);
        if (out_valid && fc_out_cnt == OUT_FEATURE) state_n = DONE;
      end
      DONE: begin
        end_op  = 1'b1;
        state_n = IDLE;
      end
      default:  state_n = IDLE;
    endcase
  end

  // Padded taps read as zero; index arithmetic is signed so negative rows/cols are caught.
  always_comb begin
    int ir, ic;
    ir     = int'(cv_r) * STRIDE + int'(cv_kr) - PAD;
    ic     = int'(cv_c) * STRIDE + int'(cv_kc) - PAD;
    conv_a = '0;
    if (ir >= 0 && ir < IFM_SIZE && ic >= 0 && ic < IFM_SIZE)
      conv_a = ifm_buf[IB_AW'((int'(cv_ci) * IFM_SIZE + ir) * IFM_SIZE + ic)];
    conv_b = wgt_buf[WB_AW'(((cv_co * CI + cv_ci) * KERNEL_SIZE + cv_kr) * KERNEL_SIZE + cv_kc)];
  end

  always_comb begin
    logic signed [DATA_WIDTH-1:0] cand;
    pool_max = conv_buf[CB_AW'((pl_co * OH + pl_r * STRIDE_POOL) * OH + pl_c * STRIDE_POOL)];
    for (int unsigned wr = 0; wr < KERNEL_POOL; wr++) begin
      for (int unsigned wc = 0; wc < KERNEL_POOL; wc++) begin
        cand = conv_buf[CB_AW'((pl_co * OH + pl_r * STRIDE_POOL + wr) * OH + pl_c * STRIDE_POOL + wc)];
        if (cand > pool_max) pool_max = cand;
      end
    end
  end

  always_comb begin
    fc_sum = '0;
    for (int unsigned i = 0; i < 8; i++) fc_sum = fc_sum + fc_acc[3'(i)];
  end

`ifdef CNN_TOP_FC_RELU_EN
  always_comb fc_res = fc_sum[DATA_WIDTH-1] ? '0 : fc_sum;
`else
  always_comb fc_res = fc_sum;
`endif

  cnn_mac #(.A_W(IFM_WIDTH), .B_W(WEIGHT_WIDTH), .ACC_W(DATA_WIDTH)) u_conv_mac (
    .clk1(clk1), .rst_n(rst_n), .clr(conv_clr), .en(conv_en),
    .a(conv_a), .b(conv_b), .acc(conv_acc)
  );

  for (genvar i = 0; i < 8; i++) begin : g_fc
    cnn_mac #(.A_W(DATA_WIDTH), .B_W(WEIGHT_WIDTH), .ACC_W(DATA_WIDTH)) u_fc_mac (
      .clk1(clk1), .rst_n(rst_n), .clr(fc_clr), .en(fc_cap),
      .a(pool_buf[PB_AW'(fc_w * 8 + i)]),
      .b(wgt_fc1[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
      .acc(fc_acc[i])
    );
  end

  always_ff @(posedge clk1) begin
    if (ifm_cap) ifm_buf[IB_AW'(cap_addr)] <= ifm;
    if (wgt_cap) wgt_buf[WB_AW'(cap_addr)] <= wgt;
    if (cv_wr)   conv_buf[cv_wr_addr] <= (RELU != 0 && conv_acc < 0) ? '0 : conv_acc;
    if (state == POOL) pool_buf[PB_AW'(pl_idx)] <= pool_max;
  end

  // Captures trail their strobe by one cycle, so the last load word lands after the state moves on.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rd_cnt <= '0; cap_addr <= '0;
      ifm_cap <= 1'b0; wgt_cap <= 1'b0; fc_cap <= 1'b0;
      cv_co <= '0; cv_r <= '0; cv_c <= '0; cv_ci <= '0; cv_kr <= '0; cv_kc <= '0;
      cv_wr <= 1'b0; cv_wr_addr <= '0;
      pl_co <= '0; pl_r <= '0; pl_c <= '0; pl_idx <= '0;
      fc_w <= '0; fc_pend <= 1'b0; fc_out_cnt <= '0;
      end_pool <= 1'b0; out_valid <= 1'b0; data_output <= '0;
    end else begin
      state    <= state_n;
      cap_addr <= CAP_AW'(rd_cnt);
      ifm_cap  <= ifm_read;
      wgt_cap  <= wgt_read;
      fc_cap   <= wgt_read_fc_1;
      if (state_n != state) rd_cnt <= '0;
      else if (ifm_read || wgt_read || wgt_read_fc_1) rd_cnt <= rd_cnt + 32'd1;

      cv_wr      <= conv_en && tap_last;
      cv_wr_addr <= CB_AW'((cv_co * OH + cv_r) * OH + cv_c);
      if (conv_en) begin
        if (cv_kc != KERNEL_SIZE-1) cv_kc <= cv_kc + 32'd1;
        else begin
          cv_kc <= '0;
          if (cv_kr != KERNEL_SIZE-1) cv_kr <= cv_kr + 32'd1;
          else begin
            cv_kr <= '0;
            if (cv_ci != CI-1) cv_ci <= cv_ci + 32'd1;
            else begin
              cv_ci <= '0;
              if (cv_c != OH-1) cv_c <= cv_c + 32'd1;
              else begin
                cv_c <= '0;
                if (cv_r != OH-1) cv_r <= cv_r + 32'd1;
                else begin
                  cv_r  <= '0;
                  cv_co <= (cv_co == CO-1) ? '0 : cv_co + 32'd1;
                end
              end
            end
          end
        end
      end

      end_pool <= (state == POOL) && (pl_idx == IN_FEATURE-1);
      if (state == POOL) begin
        pl_idx <= (pl_idx == IN_FEATURE-1) ? '0 : pl_idx + 32'd1;
        if (pl_c != PH-1) pl_c <= pl_c + 32'd1;
        else begin
          pl_c <= '0;
          if (pl_r != PH-1) pl_r <= pl_r + 32'd1;
          else begin
            pl_r  <= '0;
            pl_co <= (pl_co == CO-1) ? '0 : pl_co + 32'd1;
          end
        end
      end

      if (fc_cap) fc_w <= (fc_w == WPO-1) ? '0 : fc_w + 32'd1;
      fc_pend   <= fc_cap && (fc_w == WPO-1);
      out_valid <= fc_pend;
      if (fc_pend) begin
        data_output <= fc_res;
        fc_out_cnt  <= fc_out_cnt + 32'd1;
      end else if (state == DONE) begin
        fc_out_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cnn_top.sv
// Directed self-checking bench for cnn_top with default geometry (8x8x2 IFM, 3x3 conv, 2x2 pool, 4 FC outputs).
module tb_cnn_top;

  logic clk1 = 1'b0;
  logic rst_n = 1'b0;
  logic start_conv = 1'b0;
  logic signed [15:0] ifm = '0;
  logic signed [7:0]  wgt = '0;
  logic [63:0] wgt_fc1 = '0;
  logic ifm_read, wgt_read, wgt_read_fc_1, end_pool, end_op, out_valid;
  logic signed [31:0] data_output;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int s_cyc = 0;

  logic mon_clr = 1'b0;
  logic fc_seen = 1'b0;
  int ifm_cnt, ifm_first, ifm_last, wgt_cnt, wgt_first, wgt_last;
  int fc_cnt, fc_first, ep_cnt, eo_cnt, eo_cyc, ov_last;
  longint ov_q[$];

  int fc_mode = 0;
  int fc_k = 0;
  logic [7:0] fc_byte;

  cnn_top dut (
    .clk1(clk1), .rst_n(rst_n), .start_conv(start_conv),
    .ifm(ifm), .wgt(wgt), .wgt_fc1(wgt_fc1),
    .ifm_read(ifm_read), .wgt_read(wgt_read), .wgt_read_fc_1(wgt_read_fc_1),
    .end_pool(end_pool), .end_op(end_op), .out_valid(out_valid),
    .data_output(data_output)
  );

  always #5 clk1 = ~clk1;
  always @(posedge clk1) cyc <= cyc + 1;

  always @(negedge clk1) begin
    fc_seen = wgt_read_fc_1;
    if (mon_clr) begin
      ifm_cnt = 0; ifm_first = -1; ifm_last = -1;
      wgt_cnt = 0; wgt_first = -1; wgt_last = -1;
      fc_cnt = 0; fc_first = -1; ep_cnt = 0; eo_cnt = 0; eo_cyc = -1; ov_last = -1;
      ov_q.delete();
    end else begin
      if (ifm_read) begin if (ifm_cnt == 0) ifm_first = cyc; ifm_last = cyc; ifm_cnt++; end
      if (wgt_read) begin if (wgt_cnt == 0) wgt_first = cyc; wgt_last = cyc; wgt_cnt++; end
      if (wgt_read_fc_1) begin if (fc_cnt == 0) fc_first = cyc; fc_cnt++; end
      if (end_pool) ep_cnt++;
      if (out_valid) begin ov_q.push_back(longint'(data_output)); ov_last = cyc; end
      if (end_op) begin eo_cnt++; eo_cyc = cyc; end
    end
  end

  // FC weight source: word for a strobe seen in cycle t is presented throughout cycle t+1.
  always @(posedge clk1) begin
    if (mon_clr) fc_k = 0;
    else if (fc_seen) begin
      #1;
      case (fc_mode)
        0:       fc_byte = 8'h01;
        1:       fc_byte = 8'(fc_k / 4 + 1);
        default: fc_byte = 8'hFF;
      endcase
      wgt_fc1 = {8{fc_byte}};
      fc_k++;
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    @(posedge clk1); #1 mon_clr = 1'b1;
    @(posedge clk1); #1 mon_clr = 1'b0;
  endtask

  task automatic pulse_start(input logic signed [15:0] ifm_v, input logic signed [7:0] wgt_v,
                             input int mode);
    ifm = ifm_v; wgt = wgt_v; fc_mode = mode;
    clear_mon();
    @(posedge clk1); #1 start_conv = 1'b1; s_cyc = cyc;
    @(posedge clk1); #1 start_conv = 1'b0;
  endtask

  task automatic run_op(input logic signed [15:0] ifm_v, input logic signed [7:0] wgt_v,
                        input int mode, input bit inject, input longint base, input longint step);
    int n;
    pulse_start(ifm_v, wgt_v, mode);
    n = 0;
    while (eo_cnt == 0 && n < 6000) begin
      @(posedge clk1); #1;
      n++;
      if (inject) start_conv = (cyc == s_cyc + 140) || (fc_cnt == 5);
    end
    start_conv = 1'b0;
    chk("end_op_seen", longint'(eo_cnt > 0), 1);
    repeat (3) @(posedge clk1);
    @(negedge clk1);
    chk("ifm_first", ifm_first, s_cyc + 1);
    chk("ifm_cnt", ifm_cnt, 128);
    chk("ifm_last", ifm_last, s_cyc + 128);
    chk("wgt_first", wgt_first, s_cyc + 129);
    chk("wgt_cnt", wgt_cnt, 36);
    chk("wgt_last", wgt_last, s_cyc + 164);
    chk("fc_after_wgt", longint'(fc_first > wgt_last), 1);
    chk("fc_cnt", fc_cnt, 16);
    chk("end_pool_cnt", ep_cnt, 1);
    chk("out_cnt", ov_q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("out%0d", i), (i < ov_q.size()) ? ov_q[i] : 64'sh7fff_ffff_ffff, base + step * i);
    chk("end_op_cnt", eo_cnt, 1);
    chk("end_op_timing", eo_cyc, ov_last + 1);
    chk("hold_data", data_output, base + step * 3);
    chk("hold_ov_low", out_valid, 0);
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_ifm_read"}, ifm_read, 0);
    chk({pfx, "_wgt_read"}, wgt_read, 0);
    chk({pfx, "_wgt_read_fc_1"}, wgt_read_fc_1, 0);
    chk({pfx, "_end_pool"}, end_pool, 0);
    chk({pfx, "_end_op"}, end_op, 0);
    chk({pfx, "_out_valid"}, out_valid, 0);
    chk({pfx, "_data_output"}, data_output, 0);
  endtask

  initial begin
    longint neg_exp;
`ifdef CNN_TOP_FC_RELU_EN
    neg_exp = 0;
`else
    neg_exp = -576;
`endif
    repeat (3) @(posedge clk1);
    #1 chk_zero("rst");
    @(posedge clk1); #1 rst_n = 1'b1;
    @(negedge clk1);
    chk_zero("idle");

    // All ones: every pooled value is 18, each FC output 32*18 = 576.
    run_op(16'sd1, 8'sd1, 0, 1'b0, 576, 0);
    // Negative conv weights are clamped by the conv ReLU, so FC sees zeros.
    run_op(16'sd1, -8'sd1, 0, 1'b0, 0, 0);
    // Stray start pulses in LOAD_WGT and FC must change nothing.
    run_op(16'sd1, 8'sd1, 0, 1'b1, 576, 0);
    // FC weights equal to output index + 1 check output ordering.
    run_op(16'sd1, 8'sd1, 1, 1'b0, 576, 576);

    // Reset in the middle of CONV, then a clean rerun.
    pulse_start(16'sd1, 8'sd1, 0);
    repeat (300) @(posedge clk1);
    #1 rst_n = 1'b0;
    #1 chk_zero("midrst");
    @(posedge clk1); #1 rst_n = 1'b1;
    run_op(16'sd1, 8'sd1, 0, 1'b0, 576, 0);

    // FC weights of -1: raw sum -576, or 0 with the FC ReLU build option.
    run_op(16'sd1, 8'sd1, 2, 1'b0, neg_exp, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cnn_top.md
CNN_TOP -- requirements
Module: cnn_top

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, 32, accumulator/output width.
REQ-002 SHALL have parameter WEIGHT_WIDTH, 8, signed weight width.
REQ-003 SHALL have parameter IFM_WIDTH, 16, signed input pixel width.
REQ-004 SHALL have parameters IFM_SIZE 8, KERNEL_SIZE 3, STRIDE 1, PAD 1, RELU 1, CI 2, CO 2: conv geometry; RELU=1 clamps conv results below 0 to 0.
REQ-005 SHALL have parameters KERNEL_POOL 2, STRIDE_POOL 2, OUT_FEATURE 4: max-pool window/stride and FC output count.
REQ-006 SHALL derive OH=(IFM_SIZE-KERNEL_SIZE+2*PAD)/STRIDE+1, PH=(OH-KERNEL_POOL)/STRIDE_POOL+1, IN_FEATURE=CO*PH*PH, which must be a multiple of 8.
REQ-007 Ports: clk1 in 1, the single clock; all logic on its rising edge.
REQ-008 Ports: rst_n in 1, reset; asynchronous, active-low.
REQ-009 Ports: start_conv in 1, start pulse; ifm in IFM_WIDTH, pixel; wgt in WEIGHT_WIDTH, conv weight; wgt_fc1 in 8*WEIGHT_WIDTH, eight FC weights, byte i = lane i.
REQ-010 Ports: ifm_read out 1, wgt_read out 1, wgt_read_fc_1 out 1, source read strobes.
REQ-011 Ports: end_pool out 1, end_op out 1, completion pulses; out_valid out 1; data_output out DATA_WIDTH, signed result.

Function
REQ-012 SHALL run states IDLE -> LOAD_IFM -> LOAD_WGT -> CONV -> POOL -> FC -> DONE -> IDLE.
REQ-013 IDLE: start_conv sampled high moves to LOAD_IFM; start_conv in any other state is ignored.
REQ-014 Read protocol: data for a strobe asserted in cycle t is valid on the input in cycle t+1 and is captured then.
REQ-015 LOAD_IFM: ifm_read high for exactly CI*IFM_SIZE^2 consecutive cycles, starting the cycle after start is sampled; order [ci][row][col] into an internal buffer.
REQ-016 LOAD_WGT: wgt_read high for exactly CO*CI*KERNEL_SIZE^2 consecutive cycles, order [co][ci][kr][kc].
REQ-017 CONV: one signed IFM*WGT MAC per cycle; out-of-bounds padded pixels = 0; DATA_WIDTH accumulation wraps modulo 2^DATA_WIDTH; ReLU applied when RELU=1; result stored [co][r][c].
REQ-018 POOL: signed max over each KERNEL_POOL^2 window at STRIDE_POOL; result flattened [co][r][c] into IN_FEATURE vector; end_pool pulses one cycle when the last pooled value is written.
REQ-019 FC: wgt_read_fc_1 high one cycle per 8-weight word, IN_FEATURE/8 words per output, OUT_FEATURE*IN_FEATURE/8 words total, row-major [out][in]; lane i weights input in+i; 8 MACs per cycle.
REQ-020 Each FC output SHALL drive data_output with out_valid high for exactly one cycle, outputs 0..OUT_FEATURE-1 in order, no bias.
REQ-021 end_op SHALL pulse one cycle in DONE, the cycle after the last out_valid; then IDLE, ready for a new start.
REQ-022 data_output SHALL hold its last value when out_valid is low.

Reset
REQ-023 rst_n low, at any time including mid-operation, SHALL force IDLE and drive all strobes, end_pool, end_op, out_valid and data_output to 0 and clear all counters; buffers need not be cleared.

Configuration
REQ-024 Macro CNN_TOP_FC_RELU_EN defined: FC outputs below 0 are driven as 0. Undefined: FC outputs are the raw signed sums.

Structure
REQ-025 Package cnn_top_pkg SHALL hold the state enum and the derived-size constants/functions (OH, PH, IN_FEATURE).
REQ-026 A sub-module cnn_mac, a signed multiply-accumulate with clear and enable, SHALL be instantiated for conv (x1) and FC (x8 lanes summed).

Verification
REQ-027 Defaults; start_conv one cycle -> ifm_read high exactly 128 cycles from the next cycle, then wgt_read exactly 36 cycles, then no strobe until FC.
REQ-028 All ifm=1, wgt=1, wgt_fc1 bytes=1 -> end_pool once, 16 wgt_read_fc_1 cycles, 4 out_valid pulses each with data_output=576, then end_op once.
REQ-029 Same data with wgt=-1 (RELU=1) -> four outputs of 0.
REQ-030 rst_n low during CONV -> all outputs 0 immediately; a new start then repeats REQ-028 results exactly.
REQ-031 start_conv pulsed during LOAD_WGT and FC -> ignored; strobe counts and results unchanged.
REQ-032 CNN_TOP_FC_RELU_EN defined, ifm=1, wgt=1, wgt_fc1 bytes=-1 -> outputs 0; undefined -> outputs -576.
